// File: rtl/aritm_pkg.sv
// aritm_pkg: shared op encodings, FSM states and default sizes for the arithmetic units
package aritm_pkg;
  localparam int DEF_WIDTH = 28;
  localparam int DEF_LIMIT = 99_999_999;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ACC_ADD = 2'b10;
  localparam logic [1:0] OP_ACC_SUB = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_e;
endpackage

// File: rtl/verif_limita.sv
// verif_limita: decimal magnitude check of a WIDTH+1-bit signed result with all-ones saturation
module verif_limita #(
  parameter int WIDTH = 28,
  parameter int LIMIT = 99_999_999
) (
  input  logic [WIDTH:0]   r_i,
  output logic             ovf_o,
  output logic [WIDTH-1:0] d_o
);
  localparam logic signed [WIDTH:0] LIM = (WIDTH+1)'(LIMIT);
  assign ovf_o = ($signed(r_i) > LIM) || ($signed(r_i) < -LIM);
  assign d_o   = ovf_o ? '1 : r_i[WIDTH-1:0];
endmodule

// File: rtl/aritm_addsub.sv
// aritm_addsub: handshaked signed add/subtract with accumulator and decimal range check
module aritm_addsub
  import aritm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LIMIT = DEF_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  input  logic [1:0]       op,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic             clr,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] d_out,
  output logic             ovrflow,
  output logic             err_sticky,
  output logic [WIDTH-1:0] acc
);
  state_e           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d, a, b;
  logic [WIDTH-1:0] d_q, d_d, acc_q, acc_d, lim_d;
  logic             ov_q, ov_d, err_q, err_d, lim_ov;

  // a clr accepted alongside an ACC_* request makes that operation start from zero
  assign a = op[1] ? (clr ? '0 : {acc_q[WIDTH-1], acc_q}) : {n1[WIDTH-1], n1};
  assign b = {n2[WIDTH-1], n2};

  verif_limita #(.WIDTH(WIDTH), .LIMIT(LIMIT)) u_lim (
    .r_i  (r_q),
    .ovf_o(lim_ov),
    .d_o  (lim_d)
  );

  // next state and datapath: accept in IDLE, range-check in CALC, hold in OUT
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    ov_d    = ov_q;
    acc_d   = clr ? '0 : acc_q;
    err_d   = clr ? 1'b0 : err_q;
    case (state_q)
      S_IDLE: if (valid_in) begin
        state_d = S_CALC;
        r_d     = op[0] ? a - b : a + b;
      end
      S_CALC: begin
        state_d = S_OUT;
        d_d     = lim_d;
        ov_d    = lim_ov;
        if (lim_ov) err_d = 1'b1;
        else acc_d = r_q[WIDTH-1:0];
      end
      S_OUT: if (ready_out) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and result registers; reset discards any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      d_q     <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  assign ready_in   = state_q == S_IDLE;
  assign valid_out  = state_q == S_OUT;
  assign d_out      = d_q;
  assign ovrflow    = ov_q;
  assign err_sticky = err_q;
  assign acc        = acc_q;
endmodule

// File: tb/tb_aritm_addsub.sv
// tb_aritm_addsub: directed vector table plus handshake, clear and reset corner sequences
module tb_aritm_addsub;
  import aritm_pkg::*;
  localparam logic [27:0] M = 28'hFFFFFFF;
  localparam logic [27:0] L = 28'd99999999;
  localparam logic [27:0] NL = 28'(-99999999);
  localparam logic [27:0] MN = 28'h8000000;

  typedef struct {
    logic [1:0]  op;
    logic [27:0] a, b;
    logic        c;
    logic [27:0] d;
    logic        ov, err;
    logic [27:0] acc;
  } vec_t;

  logic clk = 0, rst = 0, valid_in = 0, clr = 0, ready_out = 0;
  logic [27:0] n1 = 0, n2 = 0;
  logic [1:0] op = 0;
  logic ready_in, valid_out, ovrflow, err_sticky;
  logic [27:0] d_out, acc;
  int tests = 0, fails = 0;
  vec_t v[13];

  aritm_addsub dut (
    .clk(clk), .rst(rst), .n1(n1), .n2(n2), .op(op), .valid_in(valid_in),
    .ready_in(ready_in), .clr(clr), .valid_out(valid_out), .ready_out(ready_out),
    .d_out(d_out), .ovrflow(ovrflow), .err_sticky(err_sticky), .acc(acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic start(input logic [1:0] o, input logic [27:0] a, input logic [27:0] b, input logic c);
    @(negedge clk);
    check("idle_ready", ready_in, 1);
    op = o; n1 = a; n2 = b; clr = c; valid_in = 1;
    @(negedge clk);
    valid_in = 0; clr = 0;
    check("calc_ready", ready_in, 0);
    check("calc_valid", valid_out, 0);
  endtask

  task automatic expect_out(input logic [27:0] d, input logic ov, input logic err, input logic [27:0] ac);
    check("out_valid", valid_out, 1);
    check("d_out", d_out, d);
    check("ovrflow", ovrflow, ov);
    check("err_sticky", err_sticky, err);
    check("acc", acc, ac);
  endtask

  task automatic release_out();
    ready_out = 1;
    @(negedge clk);
    ready_out = 0;
    check("back_idle", ready_in, 1);
  endtask

  initial begin
    v[0]  = '{OP_ADD,     28'd50000000, 28'd49999999, 0, L,        0, 0, L};
    v[1]  = '{OP_SUB,     NL,           28'd1,        0, M,        1, 1, L};
    v[2]  = '{OP_SUB,     28'd0,        L,            0, NL,       0, 1, NL};
    v[3]  = '{OP_ACC_ADD, 28'd12345,    28'd40000000, 1, 28'd40000000, 0, 0, 28'd40000000};
    v[4]  = '{OP_ACC_ADD, 28'd0,        28'd40000000, 0, 28'd80000000, 0, 0, 28'd80000000};
    v[5]  = '{OP_ACC_ADD, 28'd0,        28'd40000000, 0, M,        1, 1, 28'd80000000};
    v[6]  = '{OP_ACC_ADD, 28'd0,        28'd5,        1, 28'd5,    0, 0, 28'd5};
    v[7]  = '{OP_ACC_SUB, 28'd0,        28'd10,       0, 28'(-5),  0, 0, 28'(-5)};
    v[8]  = '{OP_SUB,     28'd5,        MN,           0, M,        1, 1, 28'(-5)};
    v[9]  = '{OP_ADD,     NL,           28'd0,        0, NL,       0, 1, NL};
    v[10] = '{OP_ADD,     L,            28'd1,        0, M,        1, 1, NL};
    v[11] = '{OP_ADD,     MN,           MN,           0, M,        1, 1, NL};
    v[12] = '{OP_ACC_SUB, 28'd0,        NL,           0, 28'd0,    0, 1, 28'd0};
    repeat (3) @(negedge clk);
    check("rst_ready_in", ready_in, 1);
    check("rst_valid_out", valid_out, 0);
    check("rst_d_out", d_out, 0);
    check("rst_ovrflow", ovrflow, 0);
    check("rst_err", err_sticky, 0);
    check("rst_acc", acc, 0);
    rst = 1;
    for (int i = 0; i < 13; i++) begin
      start(v[i].op, v[i].a, v[i].b, v[i].c);
      @(negedge clk);
      expect_out(v[i].d, v[i].ov, v[i].err, v[i].acc);
      release_out();
    end
    start(OP_ADD, 28'd1, 28'd2, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_in = (i == 2);
      op = OP_ADD; n1 = 28'd100; n2 = 28'd100;
      check("hold_valid", valid_out, 1);
      check("hold_ready_in", ready_in, 0);
      check("hold_d", d_out, 3);
      check("hold_ov", ovrflow, 0);
    end
    valid_in = 0;
    release_out();
    @(negedge clk);
    check("pulse_ignored", ready_in, 1);
    check("pulse_acc", acc, 3);
    start(OP_ADD, L, L, 0);
    @(negedge clk);
    release_out();
    start(OP_ADD, 28'd7, 28'd8, 0);
    clr = 1;
    @(negedge clk);
    clr = 0;
    expect_out(28'd15, 0, 0, 28'd15);
    release_out();
    start(OP_ADD, L, L, 0);
    clr = 1;
    @(negedge clk);
    clr = 0;
    expect_out(M, 1, 1, 28'd0);
    release_out();
    start(OP_ADD, 28'd1, 28'd1, 0);
    rst = 0;
    #1;
    check("arst_ready_in", ready_in, 1);
    check("arst_valid", valid_out, 0);
    check("arst_d", d_out, 0);
    check("arst_ov", ovrflow, 0);
    check("arst_err", err_sticky, 0);
    check("arst_acc", acc, 0);
    @(negedge clk);
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      check("no_valid_after_rst", valid_out, 0);
    end
    start(OP_SUB, 28'd2, 28'd9, 0);
    @(negedge clk);
    expect_out(28'(-7), 0, 0, 28'(-7));
    release_out();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
